// File: rtl/ram_arb_pkg.sv
// Shared encodings for the RAM port arbiter: FSM states and requester indices.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/arb_rr_pick.sv
// 2-way combinational picker. Round-robin by default; RAM_ARB_CPU_PRIO_EN selects fixed CPU priority.
import ram_arb_pkg::*;

module arb_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o
);

`ifdef RAM_ARB_CPU_PRIO_EN
  logic unused_last;
  assign unused_last = last_i;

  always_comb begin
    grant_o = PORT_CPU;
    if (!req_i[PORT_CPU] && req_i[PORT_HOST]) grant_o = PORT_HOST;
  end
`else
  always_comb begin
    grant_o = PORT_CPU;
    if (req_i[PORT_CPU] && req_i[PORT_HOST]) begin
      grant_o = ~last_i;
    end else if (req_i[PORT_HOST]) begin
      grant_o = PORT_HOST;
    end
  end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between the CPU and host ports.
// Define RAM_ARB_CPU_PRIO_EN for fixed CPU priority instead of round-robin.
import ram_arb_pkg::*;

module ram_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  generate
    if (RAM_LAT != 1) begin : g_lat_chk
      $error("ram_port_arbiter: only RAM_LAT=1 is supported");
    end
  endgenerate

  state_e            state_q;
  logic              grant_q;
  logic              last_grant_q;
  logic              we_q;
  logic              ram_en_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              cpu_ack_q;
  logic              host_ack_q;

  logic [1:0]        req_vec;
  logic              grant_d;

  assign req_vec = {host_req, cpu_req};

  arb_rr_pick u_pick (
    .req_i   (req_vec),
    .last_i  (last_grant_q),
    .grant_o (grant_d)
  );

  // Handshake: a requester raises req with stable we/addr/wdata and holds it
  // until its one-cycle ack; request inputs are only sampled in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= PORT_CPU;
      last_grant_q <= PORT_HOST;
      we_q         <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_vec) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            ram_en_q     <= 1'b1;
            if (grant_d == PORT_CPU) begin
              ram_addr_q  <= cpu_addr;
              ram_wdata_q <= cpu_wdata;
              ram_we_q    <= cpu_we;
              we_q        <= cpu_we;
            end else begin
              ram_addr_q  <= host_addr;
              ram_wdata_q <= host_wdata;
              ram_we_q    <= host_we;
              we_q        <= host_we;
            end
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          ram_en_q   <= 1'b0;
          ram_we_q   <= 1'b0;
          cpu_ack_q  <= (grant_q == PORT_CPU);
          host_ack_q <= (grant_q == PORT_HOST);
          state_q    <= RESP;
        end
        RESP: begin
          cpu_ack_q  <= 1'b0;
          host_ack_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM data arrives in the RESP cycle, so read data is steered straight through.
  assign cpu_rdata  = (cpu_ack_q  && !we_q) ? ram_rdata : '0;
  assign host_rdata = (host_ack_q && !we_q) ? ram_rdata : '0;

  assign cpu_ack   = cpu_ack_q;
  assign host_ack  = host_ack_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural 1-cycle RAM and a reference memory model.
module tb_ram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        host_req, host_we;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        host_ack;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata, ram_rdata;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] cpu_exp_q[$];
  logic [15:0] host_exp_q[$];
  logic [15:0] model_mem [0:255];
  bit          valid [0:255];
  logic [15:0] ram_mem [0:255];

  ram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .host_ack(host_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_cpu(input logic we, input logic [7:0] addr, input logic [15:0] wdata);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
  endtask

  task automatic drive_host(input logic we, input logic [7:0] addr, input logic [15:0] wdata);
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
  endtask

  // Called right after req is driven in cycle 0; lat is the ack cycle index or -1.
  task automatic wait_ack(input bit is_cpu, output int lat);
    lat = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if ((is_cpu && cpu_ack) || (!is_cpu && host_ack)) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic host_write(input logic [7:0] addr, input logic [15:0] data);
    int lat;
    @(posedge clk); #1;
    drive_host(1'b1, addr, data);
    wait_ack(1'b0, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL host_write_latency addr=%0h: got %0d want 2", addr, lat);
    end
    model_mem[addr] = data;
    valid[addr] = 1'b1;
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, cpu_ack, host_ack, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000", {ram_en, ram_we, cpu_ack, host_ack, busy});
    end
    checks++;
    if ({ram_addr, ram_wdata} !== 24'h0) begin
      errors++;
      $display("FAIL reset_ram_bus: got addr=%0h wdata=%0h want 0", ram_addr, ram_wdata);
    end
    checks++;
    if ({cpu_rdata, host_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got cpu=%0h host=%0h want 0", cpu_rdata, host_rdata);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_host_write_cpu_read;
    int lat;
    host_exp_q.push_back(16'h0);
    @(posedge clk); #1;
    drive_host(1'b1, 8'h05, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h05, 16'h1234}) begin
      errors++;
      $display("FAIL hw_access: got en=%b we=%b addr=%0h wdata=%0h want 1 1 05 1234",
               ram_en, ram_we, ram_addr, ram_wdata);
    end
    @(negedge clk);
    checks++;
    if ({host_ack, cpu_ack} !== 2'b10) begin
      errors++;
      $display("FAIL hw_ack: got host=%b cpu=%b want 1 0", host_ack, cpu_ack);
    end
    checks++;
    if (host_rdata !== host_exp_q.pop_front()) begin
      errors++;
      $display("FAIL hw_rdata: got %0h want 0", host_rdata);
    end
    model_mem[8'h05] = 16'h1234;
    valid[8'h05] = 1'b1;
    @(posedge clk); #1;
    host_req = 1'b0;

    cpu_exp_q.push_back(model_mem[8'h05]);
    @(posedge clk); #1;
    drive_cpu(1'b0, 8'h05, 16'h0);
    wait_ack(1'b1, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL hw_cpu_latency: got %0d want 2", lat);
    end
    checks++;
    if (cpu_rdata !== cpu_exp_q.pop_front()) begin
      errors++;
      $display("FAIL hw_cpu_rdata: got %0h want 1234", cpu_rdata);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic test_single_cpu_read;
    logic [15:0] exp;
    host_write(8'h10, 16'hBEEF);
    cpu_exp_q.push_back(model_mem[8'h10]);
    @(posedge clk); #1;
    drive_cpu(1'b0, 8'h10, 16'h0);
    @(negedge clk);
    checks++;
    if ({cpu_stall, ram_en} !== 2'b10) begin
      errors++;
      $display("FAIL scr_cycle0: got stall=%b en=%b want 1 0", cpu_stall, ram_en);
    end
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, ram_addr, cpu_stall, cpu_ack} !== {1'b1, 1'b0, 8'h10, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL scr_cycle1: got en=%b we=%b addr=%0h stall=%b ack=%b want 1 0 10 1 0",
               ram_en, ram_we, ram_addr, cpu_stall, cpu_ack);
    end
    @(negedge clk);
    checks++;
    if ({cpu_ack, ram_en, cpu_stall} !== 3'b100) begin
      errors++;
      $display("FAIL scr_cycle2: got ack=%b en=%b stall=%b want 1 0 0", cpu_ack, ram_en, cpu_stall);
    end
    exp = cpu_exp_q.pop_front();
    checks++;
    if (cpu_rdata !== exp) begin
      errors++;
      $display("FAIL scr_rdata: got %0h want %0h", cpu_rdata, exp);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic test_round_robin;
    int  exp_cyc [4];
    bit  exp_port [4];
    int  n;
    logic [15:0] exp;
    host_write(8'h20, 16'hA1A1);
    host_write(8'h30, 16'hB2B2);
    exp_cyc = '{2, 5, 8, 11};
`ifdef RAM_ARB_CPU_PRIO_EN
    exp_port = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    for (int i = 0; i < 4; i++) begin
      if (exp_port[i]) host_exp_q.push_back(model_mem[8'h30]);
      else             cpu_exp_q.push_back(model_mem[8'h20]);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    drive_cpu(1'b0, 8'h20, 16'h0);
    drive_host(1'b0, 8'h30, 16'h0);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (cpu_ack && host_ack) begin
        checks++; errors++;
        $display("FAIL rr_double_ack cycle %0d: got both acks want one", c);
      end else if (cpu_ack || host_ack) begin
        if (n < 4) begin
          checks++;
          if (host_ack !== exp_port[n]) begin
            errors++;
            $display("FAIL rr_order #%0d: got port %0d want %0d", n, host_ack, exp_port[n]);
          end
          checks++;
          if (c != exp_cyc[n]) begin
            errors++;
            $display("FAIL rr_cycle #%0d: got %0d want %0d", n, c, exp_cyc[n]);
          end
        end
        if (host_ack && host_exp_q.size() > 0) begin
          exp = host_exp_q.pop_front();
          checks++;
          if (host_rdata !== exp) begin
            errors++;
            $display("FAIL rr_host_rdata: got %0h want %0h", host_rdata, exp);
          end
        end else if (cpu_ack && cpu_exp_q.size() > 0) begin
          exp = cpu_exp_q.pop_front();
          checks++;
          if (cpu_rdata !== exp) begin
            errors++;
            $display("FAIL rr_cpu_rdata: got %0h want %0h", cpu_rdata, exp);
          end
        end
        n++;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    host_req = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rr_count: got %0d acks want 4", n);
    end
    cpu_exp_q.delete();
    host_exp_q.delete();
  endtask

  task automatic test_back_to_back;
    int lat;
    cpu_exp_q.push_back(16'h0);
    model_mem[8'h40] = 16'hCAFE;
    valid[8'h40] = 1'b1;
    @(posedge clk); #1;
    drive_cpu(1'b1, 8'h40, 16'hCAFE);
    wait_ack(1'b1, lat);
    checks++;
    if (lat !== 2 || cpu_rdata !== cpu_exp_q.pop_front()) begin
      errors++;
      $display("FAIL b2b_write: got lat=%0d rdata=%0h want 2 0", lat, cpu_rdata);
    end
    @(posedge clk); #1;
    cpu_we = 1'b0;
    cpu_exp_q.push_back(model_mem[8'h40]);
    wait_ack(1'b1, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL b2b_read_latency: got %0d want 2", lat);
    end
    checks++;
    if (cpu_rdata !== cpu_exp_q.pop_front()) begin
      errors++;
      $display("FAIL b2b_read_rdata: got %0h want cafe", cpu_rdata);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic test_input_change;
    logic [15:0] exp;
    host_write(8'h20, 16'h2020);
    cpu_exp_q.push_back(model_mem[8'h10]);
    @(posedge clk); #1;
    drive_cpu(1'b0, 8'h10, 16'h0);
    @(posedge clk); #1;
    cpu_addr = 8'h20; cpu_we = 1'b1; cpu_wdata = 16'hDEAD;
    @(negedge clk);
    checks++;
    if ({ram_addr, ram_we} !== {8'h10, 1'b0}) begin
      errors++;
      $display("FAIL chg_latched: got addr=%0h we=%b want 10 0", ram_addr, ram_we);
    end
    @(negedge clk);
    exp = cpu_exp_q.pop_front();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== exp) begin
      errors++;
      $display("FAIL chg_result: got ack=%b rdata=%0h want 1 %0h", cpu_ack, cpu_rdata, exp);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_reset_abort;
    logic [15:0] exp;
    @(posedge clk); #1;
    drive_cpu(1'b0, 8'h10, 16'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd1) begin
      errors++;
      $display("FAIL abort_in_access: got state %0d want 1", dbg_state);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({cpu_ack, host_ack, ram_en, ram_we, busy, dbg_state, ram_addr, cpu_rdata} !== 31'h0) begin
      errors++;
      $display("FAIL abort_cleared: got ack=%b en=%b busy=%b state=%0d addr=%0h rdata=%0h want 0",
               cpu_ack, ram_en, busy, dbg_state, ram_addr, cpu_rdata);
    end
    cpu_exp_q.push_back(model_mem[8'h10]);
    @(negedge clk);
    checks++;
    if ({ram_en, cpu_ack} !== 2'b10) begin
      errors++;
      $display("FAIL abort_fresh_access: got en=%b ack=%b want 1 0", ram_en, cpu_ack);
    end
    @(negedge clk);
    exp = cpu_exp_q.pop_front();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== exp) begin
      errors++;
      $display("FAIL abort_fresh_ack: got ack=%b rdata=%0h want 1 %0h", cpu_ack, cpu_rdata, exp);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic test_random;
    bit          is_cpu, we;
    logic [7:0]  addr;
    logic [15:0] data, exp;
    int          lat;
    for (int i = 0; i < 24; i++) begin
      is_cpu = 1'($urandom_range(0, 1));
      addr   = 8'h80 + 8'($urandom_range(0, 15));
      we     = !valid[addr] || ($urandom_range(0, 1) == 1);
      data   = 16'($urandom_range(0, 16'hFFFF));
      exp    = we ? 16'h0 : model_mem[addr];
      if (is_cpu) cpu_exp_q.push_back(exp);
      else        host_exp_q.push_back(exp);
      if (we) begin
        model_mem[addr] = data;
        valid[addr] = 1'b1;
      end
      @(posedge clk); #1;
      if (is_cpu) drive_cpu(we, addr, data);
      else        drive_host(we, addr, data);
      wait_ack(is_cpu, lat);
      checks++;
      if (lat !== 2) begin
        errors++;
        $display("FAIL rnd_latency #%0d: got %0d want 2", i, lat);
      end
      checks++;
      if ((is_cpu ? host_ack : cpu_ack) !== 1'b0) begin
        errors++;
        $display("FAIL rnd_wrong_ack #%0d: got other ack 1 want 0", i);
      end
      exp = is_cpu ? cpu_exp_q.pop_front() : host_exp_q.pop_front();
      checks++;
      if ((is_cpu ? cpu_rdata : host_rdata) !== exp) begin
        errors++;
        $display("FAIL rnd_rdata #%0d addr=%0h: got %0h want %0h", i, addr,
                 is_cpu ? cpu_rdata : host_rdata, exp);
      end
      @(posedge clk); #1;
      cpu_req = 1'b0;
      host_req = 1'b0;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_host_write_cpu_read();
    test_single_cpu_read();
    test_round_robin();
    test_back_to_back();
    test_input_change();
    test_reset_abort();
    test_random();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
